// File: rtl/ldpc_iter_ctrl.sv
// Top-level sequencer for the LDPC decoder core. It runs IDLE -> DATA_IN -> ITER -> DATA_OUT.
// All outputs are registered, so done goes high on the cycle after the final word is accepted.
module ldpc_iter_ctrl #(
  parameter int CNT_W     = 13,
  parameter int ITER_W    = 5,
  parameter int PH_W      = 2,
  parameter int PHASES    = 3,
  parameter int ITER_LEN  = 4608,
  parameter int MIN_ITER  = 1,
  parameter int OUT_LEN_0 = 6912,
  parameter int OUT_LEN_1 = 4608,
  parameter int OUT_LEN_2 = 5760,
  parameter int OUT_LEN_3 = 6336
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync_in,
  input  logic [1:0]        rate,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              early_en,
  input  logic              syndrome_ok,
  input  logic              out_ready,
  input  logic              abort,
  output logic [3:0]        fsm_state,
  output logic [PH_W-1:0]   phase,
  output logic [CNT_W-1:0]  cnt,
  output logic [ITER_W-1:0] num_iter,
  output logic              iter_first,
  output logic              iter_end,
  output logic              busy,
  output logic              out_valid,
  output logic              converged,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'b0001,
    S_DATA_IN  = 4'b0010,
    S_ITER     = 4'b0100,
    S_DATA_OUT = 4'b1000
  } state_t;

  localparam logic [CNT_W:0] ITER_LAST = (CNT_W+1)'(ITER_LEN - 1);

  state_t            state;
  logic              sync_q;
  logic [1:0]        rate_r;
  logic [ITER_W-1:0] max_iter_r;
  logic              early_en_r;

  logic              sync_fall;
  logic              sync_rise;
  logic [ITER_W:0]   iter_next;
  logic [ITER_W:0]   max_iter_eff;
  logic              stop_max;
  logic              stop_early;
  logic [CNT_W:0]    out_last;
  logic              last_word;
  logic              pre_iter_end;
  logic              phase_last;

  always_comb begin
    sync_fall    = sync_q & ~sync_in;
    sync_rise    = sync_in & ~sync_q;
    iter_next    = {1'b0, num_iter} + 1'b1;
    max_iter_eff = (max_iter_r == '0) ? (ITER_W+1)'(1) : {1'b0, max_iter_r};
    stop_max     = (iter_next == max_iter_eff);
    stop_early   = early_en_r & syndrome_ok & (iter_next >= (ITER_W+1)'(MIN_ITER));
    out_last     = (CNT_W+1)'(OUT_LEN_0 - 1);
    case (rate_r)
      2'd0:    out_last = (CNT_W+1)'(OUT_LEN_0 - 1);
      2'd1:    out_last = (CNT_W+1)'(OUT_LEN_1 - 1);
      2'd2:    out_last = (CNT_W+1)'(OUT_LEN_2 - 1);
      default: out_last = (CNT_W+1)'(OUT_LEN_3 - 1);
    endcase
    last_word    = ({1'b0, cnt} == out_last);
    pre_iter_end = ({1'b0, cnt} == ITER_LAST - 1'b1);
    phase_last   = (phase == PH_W'(PHASES));
  end

  // Output handshake: a word transfers on every cycle where out_valid and out_ready are both
  // high. Once raised, out_valid stays high until the last word transfers or an abort occurs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sync_q     <= 1'b0;
      rate_r     <= '0;
      max_iter_r <= '0;
      early_en_r <= 1'b0;
      phase      <= '0;
      cnt        <= '0;
      num_iter   <= '0;
      iter_first <= 1'b0;
      iter_end   <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      converged  <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync_q   <= sync_in;
      done     <= 1'b0;
      overrun  <= 1'b0;
      iter_end <= 1'b0;
      if (abort) begin
        // num_iter and converged are left alone so the aborted frame can be inspected
        state     <= S_IDLE;
        cnt       <= '0;
        phase     <= '0;
        busy      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (sync_in) begin
              state      <= S_DATA_IN;
              rate_r     <= rate;
              max_iter_r <= max_iter;
              early_en_r <= early_en;
              num_iter   <= '0;
              converged  <= 1'b0;
              iter_first <= 1'b1;
            end
          end
          S_DATA_IN: begin
            if (sync_fall) begin
              state <= S_ITER;
              cnt   <= '0;
              phase <= PH_W'(1);
              busy  <= 1'b1;
            end
          end
          S_ITER: begin
            if (sync_rise) overrun <= 1'b1;
            phase <= phase_last ? PH_W'(1) : phase + 1'b1;
            // iter_end is high exactly while cnt sits on the last position of the iteration
            if (iter_end) begin
              cnt        <= '0;
              iter_first <= 1'b0;
              num_iter   <= (&num_iter) ? num_iter : num_iter + 1'b1;
              if (stop_max || stop_early) begin
                state     <= S_DATA_OUT;
                phase     <= '0;
                out_valid <= 1'b1;
                converged <= stop_early;
              end
            end else begin
              cnt      <= cnt + 1'b1;
              iter_end <= pre_iter_end;
            end
          end
          S_DATA_OUT: begin
            if (sync_rise) overrun <= 1'b1;
            if (out_ready) begin
              if (last_word) begin
                state     <= S_IDLE;
                cnt       <= '0;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                done      <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign fsm_state = state;

endmodule
